// File: rtl/sound_arbiter.sv
// sound_arbiter: turns level sound requests into one-cycle player triggers,
// arbitrates game-over > jump > score with preemption, times each sound
// with a per-source duration and routes the chosen player's wave to audio_out.
//
// state | meaning
// IDLE  | no sound routed, waiting for a request edge
// TRIG  | one cycle: pulse trig_<src>, load duration counter
// PLAY  | route wave_<src>_in to audio_out until counter reaches 0
module sound_arbiter #(
    parameter int unsigned DUR_OVER  = 6500000,
    parameter int unsigned DUR_JUMP  = 2500000,
    parameter int unsigned DUR_SCORE = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_over,
    input  logic       req_jump,
    input  logic       req_score,
    input  logic       mute,
    input  logic       wave_over_in,
    input  logic       wave_jump_in,
    input  logic       wave_score_in,
    output logic       trig_over,
    output logic       trig_jump,
    output logic       trig_score,
    output logic       audio_out,
    output logic       busy,
    output logic [1:0] active_src
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    // Source codes double as priorities: a larger code wins.
    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_SCORE = 2'd1;
    localparam logic [1:0] SRC_JUMP  = 2'd2;
    localparam logic [1:0] SRC_OVER  = 2'd3;

    localparam logic [23:0] LOAD_OVER  = 24'(DUR_OVER - 1);
    localparam logic [23:0] LOAD_JUMP  = 24'(DUR_JUMP - 1);
    localparam logic [23:0] LOAD_SCORE = 24'(DUR_SCORE - 1);

    state_t      state, state_nxt;
    logic [1:0]  src, src_nxt;
    logic [23:0] cnt, cnt_nxt;
    logic [23:0] cnt_load;
    logic        prev_over, prev_jump, prev_score;
    logic        ev_over, ev_jump, ev_score;
    logic [1:0]  ev_pri;
    logic        ev_qual;
    logic        wave_sel;
    logic        audio_nxt;

    // Request history; reset high so a request held through reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_over  <= 1'b1;
            prev_jump  <= 1'b1;
            prev_score <= 1'b1;
        end else begin
            prev_over  <= req_over;
            prev_jump  <= req_jump;
            prev_score <= req_score;
        end
    end

    assign ev_over  = req_over  & ~prev_over;
    assign ev_jump  = req_jump  & ~prev_jump;
    assign ev_score = req_score & ~prev_score;

    // Highest-priority event this cycle; simultaneous losers are dropped.
    always_comb begin
        ev_pri = SRC_NONE;
        if (ev_over)       ev_pri = SRC_OVER;
        else if (ev_jump)  ev_pri = SRC_JUMP;
        else if (ev_score) ev_pri = SRC_SCORE;
    end

    // src is NONE in IDLE, so any event qualifies there; in TRIG/PLAY equal means restart.
    assign ev_qual = (ev_pri != SRC_NONE) && (ev_pri >= src);

    // Duration reload value for the current source.
    always_comb begin
        cnt_load = 24'd0;
        case (src)
            SRC_OVER:  cnt_load = LOAD_OVER;
            SRC_JUMP:  cnt_load = LOAD_JUMP;
            SRC_SCORE: cnt_load = LOAD_SCORE;
            default:   cnt_load = 24'd0;
        endcase
    end

    // State, source and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            src   <= SRC_NONE;
            cnt   <= 24'd0;
        end else begin
            state <= state_nxt;
            src   <= src_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: start, preempt/restart, count down, finish.
    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (ev_qual) begin
                    state_nxt = S_TRIG;
                    src_nxt   = ev_pri;
                end
            end
            S_TRIG: begin
                if (ev_qual) begin
                    state_nxt = S_TRIG;
                    src_nxt   = ev_pri;
                end else begin
                    state_nxt = S_PLAY;
                    cnt_nxt   = cnt_load;
                end
            end
            S_PLAY: begin
                if (ev_qual) begin
                    state_nxt = S_TRIG;
                    src_nxt   = ev_pri;
                end else if (cnt == 24'd0) begin
                    state_nxt = S_IDLE;
                    src_nxt   = SRC_NONE;
                end else begin
                    cnt_nxt = cnt - 24'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                src_nxt   = SRC_NONE;
                cnt_nxt   = 24'd0;
            end
        endcase
    end

    // Output decode from the state register, plus next audio sample.
    always_comb begin
        trig_over  = 1'b0;
        trig_jump  = 1'b0;
        trig_score = 1'b0;
        busy       = 1'b0;
        active_src = SRC_NONE;
        wave_sel   = 1'b0;
        audio_nxt  = 1'b0;
        case (src)
            SRC_OVER:  wave_sel = wave_over_in;
            SRC_JUMP:  wave_sel = wave_jump_in;
            SRC_SCORE: wave_sel = wave_score_in;
            default:   wave_sel = 1'b0;
        endcase
        if (state == S_TRIG) begin
            trig_over  = (src == SRC_OVER);
            trig_jump  = (src == SRC_JUMP);
            trig_score = (src == SRC_SCORE);
        end
        if (state != S_IDLE) begin
            busy       = 1'b1;
            active_src = src;
        end
        if (state == S_PLAY) begin
            audio_nxt = wave_sel & ~mute;
        end
    end

    // Registered audio pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= 1'b0;
        end else begin
            audio_out <= audio_nxt;
        end
    end

endmodule
